// File: rtl/gf_pkg.sv
// Shared constants and types for the GF(2^255 - 19) operand loader.
// The word width matches the adder's 64-bit chunk width.
package gf_pkg;

    localparam int WORD_W = 64;
    localparam int NWORDS = 4;
    localparam int FOLD_K = 19;

    localparam logic [WORD_W*NWORDS-1:0] P_MOD = (256'd1 << 255) - 256'd19;

    typedef enum logic [2:0] {
        LOAD_A,
        RED_A,
        LOAD_B,
        RED_B,
        OUT
    } state_t;

endpackage

// File: rtl/gf_serial_reducer.sv
// Word-serial reduction of a 256-bit value to canonical form mod 2^255 - 19.
// Phases 0-3 fold bit 255 back in as 19, phases 4-7 trial-subtract p, phase 7 selects.
module gf_serial_reducer
    import gf_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WORD_W*NWORDS-1:0] x,
    output logic                     done,
    output logic [WORD_W*NWORDS-1:0] y
);

    localparam int XW = WORD_W * NWORDS;

    logic          run_q;
    logic [2:0]    phase_q;
    logic [XW-1:0] t_sr;
    logic [XW-1:0] d_sr;
    logic          c_q;
    logic          bw_q;

    logic [1:0]        widx;
    logic [WORD_W-1:0] x_word;
    logic [WORD_W-1:0] fold_add;
    logic [WORD_W-1:0] p_word;
    logic [WORD_W:0]   sum;
    logic [WORD_W:0]   diff;
    logic [XW-1:0]     t_fold;
    logic [XW-1:0]     t_rot;
    logic [XW-1:0]     d_next;

    function automatic logic [WORD_W:0] add_word(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b,
                                                 input logic              cin);
        return {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
    endfunction

    // Bit WORD_W of the 65-bit difference is the outgoing borrow.
    function automatic logic [WORD_W:0] sub_word(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b,
                                                 input logic              bin);
        return {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};
    endfunction

    always_comb begin
        widx   = phase_q[1:0];
        x_word = x[int'(widx)*WORD_W +: WORD_W];
        if (widx == 2'd3) begin
            x_word[WORD_W-1] = 1'b0;
        end
        fold_add = (widx == 2'd0 && x[XW-1]) ? WORD_W'(FOLD_K) : '0;
        p_word   = P_MOD[int'(widx)*WORD_W +: WORD_W];
        sum      = add_word(x_word, fold_add, (widx == 2'd0) ? 1'b0 : c_q);
        diff     = sub_word(t_sr[WORD_W-1:0], p_word, (widx == 2'd0) ? 1'b0 : bw_q);
        t_fold   = {sum[WORD_W-1:0], t_sr[XW-1:WORD_W]};
        t_rot    = {t_sr[WORD_W-1:0], t_sr[XW-1:WORD_W]};
        d_next   = {diff[WORD_W-1:0], d_sr[XW-1:WORD_W]};
    end

    // A final borrow means t < p, so t is already canonical.
    assign done = run_q && (phase_q == 3'd7);
    assign y    = diff[WORD_W] ? t_rot : d_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            phase_q <= 3'd0;
        end else if (start) begin
            run_q   <= 1'b1;
            phase_q <= 3'd0;
        end else if (run_q) begin
            phase_q <= phase_q + 3'd1;
            if (phase_q == 3'd7) begin
                run_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run_q) begin
            if (!phase_q[2]) begin
                t_sr <= t_fold;
                c_q  <= sum[WORD_W];
            end else begin
                t_sr <= t_rot;
                d_sr <= d_next;
                bw_q <= diff[WORD_W];
            end
        end
    end

endmodule

// File: rtl/gf_operand_loader.sv
// Collects two 256-bit operands from a 64-bit word stream, reduces each mod p,
// and presents the canonical pair to the GF(p) adder with a valid/ready handshake.
module gf_operand_loader #(
    parameter int WORD_W = gf_pkg::WORD_W,
    parameter int NWORDS = gf_pkg::NWORDS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WORD_W*NWORDS-1:0] out_a,
    output logic [WORD_W*NWORDS-1:0] out_b,
    output logic                     out_valid,
    input  logic                     out_ready
);
    import gf_pkg::*;

    localparam int XW = WORD_W * NWORDS;
    localparam int CW = $clog2(NWORDS);

    state_t        state;
    logic [CW-1:0] wcnt;
    logic [XW-1:0] x_sr;
    logic          out_valid_q;

    logic          loading;
    logic          accept;
    logic          red_start;
    logic          red_done;
    logic [XW-1:0] red_y;

    assign loading   = (state == LOAD_A) || (state == LOAD_B);
    assign in_ready  = loading && !reset;
    assign accept    = in_valid && in_ready;
    assign red_start = accept && (wcnt == CW'(NWORDS - 1));
    assign out_valid = out_valid_q && !reset;

    // Least-significant word arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_sr <= {in_data, x_sr[XW-1:WORD_W]};
        end
    end

    gf_serial_reducer u_reducer (
        .clk   (clk),
        .reset (reset),
        .start (red_start),
        .x     (x_sr),
        .done  (red_done),
        .y     (red_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD_A;
            wcnt        <= '0;
            out_valid_q <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        wcnt <= wcnt + 1'b1;
                        if (red_start) begin
                            state <= RED_A;
                        end
                    end
                end
                RED_A: begin
                    if (red_done) begin
                        out_a <= red_y;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        wcnt <= wcnt + 1'b1;
                        if (red_start) begin
                            state <= RED_B;
                        end
                    end
                end
                RED_B: begin
                    if (red_done) begin
                        out_b       <= red_y;
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= LOAD_A;
                    end
                end
                default: begin
                    state       <= LOAD_A;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_operand_loader.sv
// Directed bench for gf_operand_loader: streams operand pairs, scoreboards the
// reduced pair against a mod-p model, and checks latency, stalls, backpressure and reset.
module tb_gf_operand_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out_a;
    logic [255:0] out_b;
    logic         out_valid;
    logic         out_ready;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
    } pair_t;

    localparam logic [255:0] PRIME = (256'd1 << 255) - 256'd19;

    pair_t        sb[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           first_acc;
    int           last_acc;
    logic [255:0] got_a;
    logic [255:0] got_b;

    gf_operand_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] model(input logic [255:0] x);
        logic [256:0] r;
        r = {1'b0, x};
        while (r >= {1'b0, PRIME}) r = r - {1'b0, PRIME};
        return r[255:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] w, output int acc);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {255'd0, in_ready}, 256'd1);
        tick();
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [255:0] a, input logic [255:0] b, input bit gap);
        int    acc;
        pair_t e;
        logic [511:0] ab;
        ab = {b, a};
        for (int w = 0; w < 8; w++) begin
            if (gap && (w == 2 || w == 6)) repeat (3) tick();
            send_word(ab[w*64 +: 64], acc);
            if (w == 0) first_acc = acc;
            last_acc = acc;
        end
        e.a = model(a);
        e.b = model(b);
        sb.push_back(e);
    endtask

    task automatic take(input int hold, input int exp_lat, input int exp_span);
        int    n;
        pair_t e;
        n = 0;
        out_ready = (hold == 0);
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("out_valid_rise", {255'd0, out_valid}, 256'd1);
        chk("latency", 256'(cyc + 1 - last_acc), 256'(exp_lat));
        chk("pair_span", 256'(cyc - first_acc), 256'(exp_span));
        got_a = out_a;
        got_b = out_b;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_out_a", out_a, e.a);
            chk("sb_out_b", out_b, e.b);
        end else begin
            chk("sb_empty", 256'(sb.size()), 256'd1);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_a", out_a, got_a);
            chk("hold_out_b", out_b, got_b);
            chk("hold_out_valid", {255'd0, out_valid}, 256'd1);
            chk("hold_in_ready", {255'd0, in_ready}, 256'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_out_valid", {255'd0, out_valid}, 256'd0);
        chk("post_hs_in_ready", {255'd0, in_ready}, 256'd1);
    endtask

    initial begin
        int           acc;
        logic [255:0] ra;
        logic [255:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_in_ready", {255'd0, in_ready}, 256'd0);
        chk("reset_out_valid", {255'd0, out_valid}, 256'd0);
        chk("reset_out_a", out_a, 256'd0);
        chk("reset_out_b", out_b, 256'd0);
        reset = 1'b0;
        #1;
        chk("after_reset_in_ready", {255'd0, in_ready}, 256'd1);

        // Small in-range operands, back-to-back stream, consumer always ready.
        send_pair(256'd5, 256'd7, 1'b0);
        take(0, 9, 23);
        chk("small_a", got_a, 256'd5);
        chk("small_b", got_b, 256'd7);

        // Boundary at p.
        send_pair(PRIME, PRIME - 256'd1, 1'b0);
        take(0, 9, 23);
        chk("p_to_zero", got_a, 256'd0);
        chk("p_minus_1", got_b, (256'd1 << 255) - 256'd20);

        // Values with bit 255 set must fold.
        send_pair('1, 256'd1 << 255, 1'b0);
        take(0, 9, 23);
        chk("all_ones", got_a, 256'd37);
        chk("two_255", got_b, 256'd19);

        // Input stalls between words 2/3 and 6/7.
        send_pair(256'd5, 256'd7, 1'b1);
        take(0, 9, 29);
        chk("gap_a", got_a, 256'd5);
        chk("gap_b", got_b, 256'd7);

        // Random operands with backpressure in OUT.
        for (int k = 0; k < 8; k++) begin
            ra[k*32 +: 32] = $urandom;
            rb[k*32 +: 32] = $urandom;
        end
        ra[255] = 1'b1;
        rb      = PRIME + 256'(rb[7:0]);
        send_pair(ra, rb, 1'b0);
        take(5, 9, 23);

        // Abort in RED_A phase 3, then a clean pair.
        for (int w = 0; w < 4; w++) send_word(64'hDEAD_BEEF_0000_0000 | 64'(w), acc);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("midred_reset_in_ready", {255'd0, in_ready}, 256'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midred_out_a", out_a, 256'd0);
        chk("midred_out_b", out_b, 256'd0);
        chk("midred_out_valid", {255'd0, out_valid}, 256'd0);
        chk("midred_in_ready", {255'd0, in_ready}, 256'd1);
        send_pair(256'd1, 256'd2, 1'b0);
        take(0, 9, 23);
        chk("post_abort_a", got_a, 256'd1);
        chk("post_abort_b", got_b, 256'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
